// File: rtl/note_sequencer_pkg.sv
// Shared constants for the note sequencer: tone codes,
// FSM encodings and the default ms prescaler.
package note_sequencer_pkg;

  localparam int         TONE_W       = 6;
  localparam logic [5:0] TONE_REST    = 6'd63;
  localparam logic [5:0] TONE_MAX     = 6'd47;
  localparam int         TICK_DIV_DEF = 100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  function automatic logic is_note(input logic [5:0] t);
    return t <= TONE_MAX;
  endfunction

endpackage

// File: rtl/note_sequencer_fifo.sv
// First-word fall-through note queue with flush and
// push-while-full acceptance when a pop happens the same cycle.
module note_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_pop, do_push;

  assign full  = cnt_q[AW];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + AW'(do_pop);
      wr_d  = wr_q + AW'(do_push);
      cnt_d = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push && !flush)
      mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued (tone, duration) notes with an articulation
// gap, driving a registered tone index to the tone LUT.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int DUR_W      = 10,
  parameter int GAP_MS     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [5:0]       wr_tone,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             start,
  input  logic             stop,
  input  logic             flush,
  output logic [5:0]       tone,
  output logic             tone_valid,
  output logic             busy,
  output logic             note_done,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [DUR_W-1:0]   ms_q, ms_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [5:0]         tone_q, tone_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               fifo_pop;
  logic [DUR_W+5:0]   head;
  logic [AW:0]        fifo_cnt;
  logic [5:0]         head_tone;
  logic [DUR_W-1:0]   head_dur;
  logic               avail, more, tick;
  logic [PW-1:0]      presc_inc;
  logic [DUR_W-1:0]   ms_inc;

  note_fifo #(
    .WIDTH (6 + DUR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (fifo_pop),
    .flush (flush),
    .din   ({wr_tone, wr_dur}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign head_tone = head[DUR_W+5:DUR_W];
  assign head_dur  = head[DUR_W-1:0];

  // A flush this cycle makes the queue look empty to the FSM.
  assign avail = ~fifo_empty & ~flush;
  assign more  = (fifo_cnt > (AW+1)'(1)) & ~flush;
  assign tick  = (presc_q == PRE_MAX);
  assign presc_inc = tick ? '0 : presc_q + PW'(1);
  assign ms_inc    = tick ? ms_q + DUR_W'(1) : ms_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    ms_d     = ms_q;
    dur_d    = dur_q;
    tone_d   = tone_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      tone_d  = TONE_REST;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && avail) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          presc_d = '0;
          ms_d    = '0;
          if (!avail) begin
            state_d = ST_IDLE;
          end else begin
            fifo_pop = 1'b1;
            if (head_dur == '0) begin
              state_d = more ? ST_LOAD : ST_IDLE;
            end else begin
              dur_d   = head_dur;
              tone_d  = head_tone;
              valid_d = is_note(head_tone);
              state_d = ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          presc_d = presc_inc;
          ms_d    = ms_inc;
          if (tick && ms_q == dur_q - DUR_W'(1)) begin
            presc_d = '0;
            ms_d    = '0;
            valid_d = 1'b0;
            if (GAP_MS == 0) begin
              done_d  = 1'b1;
              state_d = avail ? ST_LOAD : ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          presc_d = presc_inc;
          ms_d    = ms_inc;
          if (tick && ms_q == GAP_LEN - DUR_W'(1)) begin
            presc_d = '0;
            ms_d    = '0;
            done_d  = 1'b1;
            state_d = avail ? ST_LOAD : ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q | (wr_en & fifo_full & ~fifo_pop);
    if (flush) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      dur_q   <= '0;
      tone_q  <= TONE_REST;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tone       = tone_q;
  assign tone_valid = valid_q;
  assign note_done  = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: note-level queue model plus
// directed scenarios and a randomized run.
module tb_note_sequencer;

  localparam int TD    = 4;
  localparam int GAP   = 2;
  localparam int DW    = 10;
  localparam int DEPTH = 16;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_GAP  = 3;

  typedef struct {
    logic [5:0] t;
    int         d;
  } note_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [5:0]    wr_tone;
  logic [DW-1:0] wr_dur;
  logic          start, stop, flush;
  logic [5:0]    tone;
  logic          tone_valid, busy, note_done;
  logic          fifo_full, fifo_empty, overflow;

  note_sequencer #(
    .TICK_DIV   (TD),
    .FIFO_DEPTH (DEPTH),
    .DUR_W      (DW),
    .GAP_MS     (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_tone    (wr_tone),
    .wr_dur     (wr_dur),
    .start      (start),
    .stop       (stop),
    .flush      (flush),
    .tone       (tone),
    .tone_valid (tone_valid),
    .busy       (busy),
    .note_done  (note_done),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  note_t      mq[$];
  int         m_mode;
  int         m_rem;
  logic [5:0] m_tone;
  bit         m_valid, m_done, m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int    qs;
    bit    pop;
    note_t h;
    note_t n;
    qs     = mq.size();
    pop    = 0;
    m_done = 0;
    if (!rst_n) begin
      mq.delete();
      m_mode  = M_IDLE;
      m_rem   = 0;
      m_tone  = 6'd63;
      m_valid = 0;
      m_ovf   = 0;
      return;
    end
    if (stop) begin
      m_mode  = M_IDLE;
      m_tone  = 6'd63;
      m_valid = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start && qs > 0 && !flush) m_mode = M_LOAD;
        M_LOAD: begin
          if (flush) begin
            m_mode = M_IDLE;
          end else begin
            h   = mq.pop_front();
            pop = 1;
            if (h.d == 0) begin
              m_mode = (qs > 1) ? M_LOAD : M_IDLE;
            end else begin
              m_tone  = h.t;
              m_valid = (h.t <= 47);
              m_rem   = h.d * TD;
              m_mode  = M_PLAY;
            end
          end
        end
        M_PLAY: begin
          m_rem--;
          if (m_rem == 0) begin
            m_valid = 0;
            m_mode  = M_GAP;
            m_rem   = GAP * TD;
          end
        end
        default: begin
          m_rem--;
          if (m_rem == 0) begin
            m_done = 1;
            m_mode = (qs > 0 && !flush) ? M_LOAD : M_IDLE;
          end
        end
      endcase
    end
    if (flush) begin
      mq.delete();
      m_ovf = 0;
    end else if (wr_en) begin
      if (qs < DEPTH || pop) begin
        n.t = wr_tone;
        n.d = int'(wr_dur);
        mq.push_back(n);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("tone", int'(tone), int'(m_tone));
    chk("tone_valid", int'(tone_valid), int'(m_valid));
    chk("busy", int'(busy), int'(m_mode != M_IDLE));
    chk("note_done", int'(note_done), int'(m_done));
    chk("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
    chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic clear_in();
    wr_en   = 0;
    wr_tone = '0;
    wr_dur  = '0;
    start   = 0;
    stop    = 0;
    flush   = 0;
  endtask

  task automatic push(input int t, input int d);
    wr_en   = 1;
    wr_tone = 6'(t);
    wr_dur  = DW'(d);
    step();
    wr_en   = 0;
  endtask

  task automatic kick();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic run_idle(input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      step();
      if (!busy) break;
    end
    chk(name, int'(busy), 0);
  endtask

  initial begin
    int hi, lo, nd, c4, c6, rv;
    clear_in();
    rst_n = 0;
    m_mode = M_IDLE;
    m_tone = 6'd63;
    step();
    step();
    rst_n = 1;

    chk("rst_tone", int'(tone), 63);
    chk("rst_valid", int'(tone_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_ovf", int'(overflow), 0);

    // single A4 note, 3 ms
    push(21, 3);
    kick();
    hi = 0; lo = 0; nd = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tone_valid && tone == 6'd21) hi++;
      else if (hi > 0 && nd == 0 && !note_done) lo++;
      if (note_done) nd++;
      if (nd > 0 && !busy) break;
    end
    chk("a4_play_cycles", hi, 12);
    chk("a4_gap_cycles", lo, 8);
    chk("a4_done_pulses", nd, 1);
    chk("a4_idle_after", int'(busy), 0);

    // note, rest, skipped zero-length entry, note
    push(12, 1);
    push(63, 1);
    push(24, 0);
    push(36, 1);
    kick();
    c4 = 0; c6 = 0; rv = 0; nd = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tone_valid && tone == 6'd12) c4++;
      if (tone_valid && tone == 6'd36) c6++;
      if (tone_valid && tone == 6'd63) rv++;
      if (tone_valid && tone == 6'd24) rv++;
      if (note_done) nd++;
      if (!busy) break;
    end
    chk("seq_c4_cycles", c4, 4);
    chk("seq_c6_cycles", c6, 4);
    chk("seq_silent_ok", rv, 0);
    chk("seq_done_pulses", nd, 3);
    chk("seq_idle_after", int'(busy), 0);

    // overflow on the 17th push
    for (int i = 0; i < 16; i++) push(i, 1);
    chk("full_at_16", int'(fifo_full), 1);
    chk("no_ovf_at_16", int'(overflow), 0);
    push(40, 1);
    chk("ovf_at_17", int'(overflow), 1);
    chk("full_at_17", int'(fifo_full), 1);
    flush = 1;
    step();
    flush = 0;
    chk("flush_empty", int'(fifo_empty), 1);
    chk("flush_ovf", int'(overflow), 0);

    // stop in the middle of a long note
    push(0, 100);
    push(5, 2);
    push(7, 2);
    kick();
    for (int i = 0; i < 20 && !tone_valid; i++) step();
    chk("long_started", int'(tone_valid), 1);
    for (int i = 0; i < 50; i++) step();
    stop = 1;
    step();
    stop = 0;
    chk("stop_valid", int'(tone_valid), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(note_done), 0);
    chk("stop_tone", int'(tone), 63);
    chk("stop_kept", int'(fifo_empty), 0);
    kick();
    run_idle(200, "resume_drain");
    chk("resume_empty", int'(fifo_empty), 1);

    // reset mid-note
    push(3, 5);
    push(4, 5);
    kick();
    for (int i = 0; i < 10; i++) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_rst_tone", int'(tone), 63);
    chk("mid_rst_valid", int'(tone_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_empty", int'(fifo_empty), 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_tone = 6'($urandom_range(40, 63));
      if ($urandom % 2 == 0) wr_tone = 6'($urandom % 48);
      wr_dur  = DW'($urandom % 4);
      start   = ($urandom % 6) == 0;
      stop    = ($urandom % 80) == 0;
      flush   = ($urandom % 150) == 0;
      step();
    end
    clear_in();
    start = 1;
    step();
    start = 0;
    run_idle(2000, "final_drain");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
